// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multicycle MIPS controller (master) and
// the datapath/memory side (slave).
interface multicycle_controller_if #(
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 32
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic                mem_req;
  logic                IorD;
  logic                MemWrite;
  logic                IRWrite;
  logic                PCWrite;
  logic                PCEn;
  logic                Branch;
  logic [1:0]          PCSrc;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          aluOp;
  logic                RegDst;
  logic                MentoReg;
  logic                RegWrite;
  logic                illegal_op;
  logic [3:0]          state_o;
  logic [CNT_W-1:0]    instr_cnt;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, IorD, MemWrite, IRWrite, PCWrite, PCEn, Branch, PCSrc,
           ALUSrcA, ALUSrcB, aluOp, RegDst, MentoReg, RegWrite, illegal_op,
           state_o, instr_cnt
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, IorD, MemWrite, IRWrite, PCWrite, PCEn, Branch, PCSrc,
           ALUSrcA, ALUSrcB, aluOp, RegDst, MentoReg, RegWrite, illegal_op,
           state_o, instr_cnt
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for the multicycle MIPS datapath: sequences each
// instruction, stalls on the memory handshake, flags illegal opcodes, counts retires.
module multicycle_controller #(
  parameter int OPCODE_W = 6,
  parameter bit EN_ADDI  = 1'b1,
  parameter bit EN_JUMP  = 1'b1,
  parameter bit MEM_HS   = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    ILLEGAL = 4'd12
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

  state_t           state;
  state_t           next_state;
  logic             ready;
  logic             retire;
  logic [CNT_W-1:0] instr_cnt;

  logic       mem_req, iord, mem_write, ir_write, pc_write, pc_en, branch;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;

  assign ready = MEM_HS ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= FETCH;
      instr_cnt <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:  if (ready) next_state = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     next_state = EXEC;
          OP_LW, OP_SW: next_state = MEMADR;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      if (EN_ADDI) next_state = ADDIEX; else next_state = ILLEGAL;
          OP_J:         if (EN_JUMP) next_state = JUMP;   else next_state = ILLEGAL;
          default:      next_state = ILLEGAL;
        endcase
      end
      MEMADR: if (bus.opcode == OP_SW) next_state = MEMWR; else next_state = MEMRD;
      MEMRD:  if (ready) next_state = MEMWB;
      MEMWR:  if (ready) next_state = FETCH;
      EXEC:   next_state = ALUWB;
      ADDIEX: next_state = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP, ILLEGAL: next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  // ILLEGAL returns to FETCH without retiring anything.
  always_comb begin
    retire = (state inside {MEMWB, ALUWB, BRANCH, ADDIWB, JUMP}) ||
             ((state == MEMWR) && ready);
  end

  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ready;
        pc_write  = ready;
      end
      DECODE:  alu_src_b = 2'b11;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB:  reg_write = 1'b1;
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
    // Strobes are suppressed during reset; mux selects still follow state.
    if (!reset_n) begin
      mem_req    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
    pc_en = pc_write | (branch & bus.zero & reset_n);
  end

  assign bus.mem_req    = mem_req;
  assign bus.IorD       = iord;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.PCWrite    = pc_write;
  assign bus.PCEn       = pc_en;
  assign bus.Branch     = branch;
  assign bus.PCSrc      = pc_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.aluOp      = alu_op;
  assign bus.RegDst     = reg_dst;
  assign bus.MentoReg   = mem_to_reg;
  assign bus.RegWrite   = reg_write;
  assign bus.illegal_op = illegal_op;
  assign bus.state_o    = state;
  assign bus.instr_cnt  = instr_cnt;

endmodule
